nanov_store_uart: RTL and testbench

- Downstream consumer of the CPU's output path. Captures the low byte of `data_out` on every `store_data_out` pulse into a small byte FIFO, then serialises each byte as a UART 8N1 frame on `uart_tx`.
- It is the team's console output for nanoV programs.
- The CPU has no backpressure input, so a byte that arrives while the FIFO is full is dropped and flagged.

---
 rtl/nanov_uart_pkg.sv | 26 ++
 rtl/nanov_byte_fifo.sv | 91 +++++++++
 rtl/nanov_store_uart.sv | 194 +++++++++++++++++++
 tb/tb_nanov_store_uart.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_uart_pkg.sv
// nanov_uart_pkg
// Shared declarations for the nanoV store-to-UART console block.
//   uart_state_e    : transmitter FSM states (PARITY is only reachable when
//                     NANOV_UART_PARITY_EN is defined)
//   FRAME_DATA_BITS : data bits per UART frame
//   IDLE_LEVEL      : line level while no frame is in progress
//   even_parity()   : even parity of one data byte
package nanov_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic IDLE_LEVEL      = 1'b1;

  // XOR of all data bits; a 1 here makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] byte_in);
    return ^byte_in;
  endfunction

endpackage

// File: rtl/nanov_byte_fifo.sv
// nanov_byte_fifo
// Small byte FIFO with occupancy counter and a drop strobe for the case where
// a write arrives while full and nothing leaves on the same edge.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   push, push_data  : write request and byte
//   pop              : read request (head advances at the edge)
//   pop_data         : current head byte (valid while !empty)
//   full, empty      : occupancy flags derived from the count register
//   drop             : push && full && !pop (byte discarded this edge)
module nanov_byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic       drop
);
  import nanov_uart_pkg::*;

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign pop_data  = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign drop      = push && full && !pop;

  // Next-state pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/nanov_store_uart.sv
// nanov_store_uart
// Console output for nanoV programs: every store_data_out pulse captures
// data_out[7:0] into a byte FIFO; bytes are sent as UART frames on uart_tx
// (8N1, or 8E1 when NANOV_UART_PARITY_EN is defined).
// Ports:
//   clk, rstn       : system clock, asynchronous active-low reset
//   store_data_out  : one-cycle store strobe, sampled every cycle
//   data_out        : CPU data word, low byte used
//   clear_overflow  : synchronous clear of the overflow flag
//   uart_tx         : registered serial line, idle high
//   fifo_full/empty : FIFO occupancy flags
//   tx_busy         : frame in progress
//   overflow        : sticky, a byte was dropped because the FIFO was full
module nanov_store_uart #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        store_data_out,
  input  logic [31:0] data_out,
  input  logic        clear_overflow,
  output logic        uart_tx,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        tx_busy,
  output logic        overflow
);
  import nanov_uart_pkg::*;

  localparam int            BAUD_W      = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(FRAME_DATA_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
`ifdef NANOV_UART_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              fifo_pop_s;
  logic [7:0]        fifo_head_s;
  logic              fifo_drop_s;
  logic              baud_done_s;
  logic              data_unused_s;

  assign data_unused_s = ^data_out[31:8];

  nanov_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (store_data_out),
    .push_data (data_out[7:0]),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop_s)
  );

  assign baud_done_s = (baud_q == {BAUD_W{1'b0}});

  // FSM next state, baud counter, shift register and line level.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop_s = 1'b0;
`ifdef NANOV_UART_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_s = 1'b1;
          shift_d    = fifo_head_s;
`ifdef NANOV_UART_PARITY_EN
          parity_d   = even_parity(fifo_head_s);
`endif
          state_d    = START;
          baud_d     = BAUD_RELOAD;
        end else begin
          state_d    = IDLE;
        end
      end
      START: begin
        if (baud_done_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_RELOAD;
        end else begin
          baud_d    = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = BAUD_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
`ifdef NANOV_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`ifdef NANOV_UART_PARITY_EN
      PARITY: begin
        if (baud_done_s) begin
          state_d = STOP;
          baud_d  = BAUD_RELOAD;
        end else begin
          baud_d  = baud_q - BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done_s) begin
          state_d = IDLE;
        end else begin
          baud_d  = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level follows the state being entered so uart_tx stays a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef NANOV_UART_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);

    // A drop on the same edge as a clear leaves the flag set.
    if (fifo_drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmitter and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= {BAUD_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef NANOV_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
`ifdef NANOV_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign uart_tx  = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nanov_store_uart.sv
// tb_nanov_store_uart
// Self-checking bench: a cycle-level reference model (byte queue plus frame
// timing arithmetic) predicts flags and the line level; a separate monitor
// decodes frames off uart_tx and checks them against the expected-byte queue.
module tb_nanov_store_uart;

  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef NANOV_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * D;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st = 1'b0;
  logic [31:0] dat = 32'h0;
  logic        clr = 1'b0;
  logic        uart_tx, fifo_full, fifo_empty, tx_busy, overflow;

  logic        rstn2 = 1'b0;
  logic        st2 = 1'b0;
  logic [31:0] dat2 = 32'h0;
  logic        uart_tx2, fifo_full2, fifo_empty2, tx_busy2, overflow2;

  always #5 clk = ~clk;

  nanov_store_uart #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .store_data_out(st), .data_out(dat),
    .clear_overflow(clr), .uart_tx(uart_tx), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .tx_busy(tx_busy), .overflow(overflow)
  );

  nanov_store_uart #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rstn(rstn2), .store_data_out(st2), .data_out(dat2),
    .clear_overflow(1'b0), .uart_tx(uart_tx2), .fifo_full(fifo_full2),
    .fifo_empty(fifo_empty2), .tx_busy(tx_busy2), .overflow(overflow2)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [7:0] model_fifo[$];
  logic [7:0] exp_q[$];
  int         e;
  int         last_edge;
  int         pop_ok;
  int         busy_until;
  int         pop_edge;
  logic [7:0] frame_byte;
  logic       ovf_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level o clocks into a frame of byte b with div clocks per bit.
  function automatic logic frame_level(input logic [7:0] b, input int o, input int div);
    int bi;
    if (o < 0 || o >= NBITS * div) return 1'b1;
    bi = o / div;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    if (bi == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic model_reset();
    model_fifo.delete();
    exp_q.delete();
    e          = 0;
    last_edge  = -1;
    pop_ok     = 0;
    busy_until = -1;
    pop_edge   = -100000;
    frame_byte = 8'h00;
    ovf_m      = 1'b0;
  endtask

  // Called just after a negedge: check outputs, drive inputs, advance model.
  task automatic step(input logic s, input logic [31:0] d, input logic c);
    logic pop, full;
    chk("fifo_full", fifo_full, model_fifo.size() == DEPTH);
    chk("fifo_empty", fifo_empty, model_fifo.size() == 0);
    chk("overflow", overflow, ovf_m);
    chk("tx_busy", tx_busy, last_edge < busy_until);
    chk("uart_tx", uart_tx, frame_level(frame_byte, last_edge - pop_edge, D));
    st = s; dat = d; clr = c;
    pop  = (model_fifo.size() > 0) && (e >= pop_ok);
    full = (model_fifo.size() == DEPTH);
    if (pop) begin
      frame_byte = model_fifo.pop_front();
      pop_edge   = e;
      busy_until = e + FRAME;
      pop_ok     = e + FRAME + 1;
    end
    if (s && (!full || pop)) begin
      model_fifo.push_back(d[7:0]);
      exp_q.push_back(d[7:0]);
    end
    if (s && full && !pop) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    last_edge = e;
    e++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((model_fifo.size() != 0 || last_edge < busy_until + D) && n < 3000) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected under 3000", n);
    end
    chk("exp_queue_drained", exp_q.size(), 0);
  endtask

  // Frame monitor: decode uart_tx at mid-bit and score against exp_q.
  initial begin : monitor
    logic [NBITS-1:0] bits, eb;
    logic             abort;
    logic [7:0]       b;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && uart_tx === 1'b0) begin
        abort = 1'b0;
        bits  = '0;
        for (int k = 0; k < D / 2; k++) begin
          @(negedge clk);
          if (rstn !== 1'b1) abort = 1'b1;
        end
        bits[0] = uart_tx;
        for (int i = 1; i < NBITS; i++) begin
          for (int k = 0; k < D; k++) begin
            @(negedge clk);
            if (rstn !== 1'b1) abort = 1'b1;
          end
          bits[i] = uart_tx;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL spurious_frame: got frame %b expected no frame", bits);
          end else begin
            b  = exp_q.pop_front();
            eb = '0;
            eb[8:1] = b;
            eb[NBITS-1] = 1'b1;
            if (NBITS == 11) eb[9] = ^b;
            chk("frame_bits", 32'(bits), 32'(eb));
          end
        end
      end
    end
  end

  initial begin : stim
    int o;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // Single byte 0x41
    step(1'b1, 32'h1234_5641, 1'b0);
    drain();

    // Burst 0x01..0x04
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0);
    drain();

    // Overflow: 0x10..0x15, then clear, then clear coinciding with a drop
    for (int i = 0; i < 6; i++) step(1'b1, 32'h10 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h20, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    drain();

    // Parity-sensitive bytes
    step(1'b1, 32'h07, 1'b0);
    drain();
    step(1'b1, 32'h03, 1'b0);
    drain();

    // Reset in the middle of data bit 3, second byte still queued
    step(1'b1, 32'h5A, 1'b0);
    step(1'b1, 32'hC3, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_uart_tx", uart_tx, 1'b1);
    chk("async_rst_fifo_empty", fifo_empty, 1'b1);
    chk("async_rst_tx_busy", tx_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 32'h0, 1'b0);

    // Randomised traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 30, $urandom, $urandom_range(0, 99) < 5);
    end
    drain();

    // CLK_DIV=2 instance: one byte, level checked every clock
    st = 1'b0;
    rstn2 = 1'b1;
    st2 = 1'b1;
    dat2 = 32'hFFFF_FFA5;
    @(negedge clk);
    st2 = 1'b0;
    chk("div2_fifo_full", fifo_full2, 1'b0);
    chk("div2_overflow", overflow2, 1'b0);
    for (int k = 0; k < NBITS * 2 + 4; k++) begin
      o = k - 1;
      chk("div2_fifo_empty", fifo_empty2, k != 0);
      chk("div2_uart_tx", uart_tx2, frame_level(8'hA5, o, 2));
      chk("div2_tx_busy", tx_busy2, (o >= 0) && (o < NBITS * 2));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
